// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl
// ----------------------------------------------------------------------------
// MEM-stage controller placed between the EX/MEM pipeline register and the
// data memory. Non-memory instructions pass straight through to the MEM/WB
// register in one cycle. Loads and stores run a req/ack transaction against
// data memory. The upstream pipeline is stalled until that transaction
// completes, and then the MEM/WB register is loaded. Misaligned accesses are
// rejected without touching memory. Transactions that see no ack within
// TIMEOUT cycles are aborted. Both cases raise a one-cycle mem_error pulse.
//
// Parameters:
//   TIMEOUT  - maximum number of WAIT cycles without dmem_ack before the
//              access is aborted (>= 2)
//   CNT_W    - width of the timeout counter (2**CNT_W > TIMEOUT)
//
// Ports:
//   clk                 in   pipeline clock, rising edge
//   rst_n               in   asynchronous active-low reset
//   ALU_result_MEM      in   effective address (ld/st) or passthrough result
//   Read_Data_2_MEM     in   store data
//   MemRead_MEM         in   load
//   MemWrite_MEM        in   store (wins if both MemRead and MemWrite are set)
//   MemToReg_MEM        in   writeback selects memory data
//   RegWrite_MEM        in   instruction writes the register file
//   Write_register_MEM  in   destination register
//   stall_MEM           out  combinational; holds PC, IF/ID, ID/EX, EX/MEM
//   dmem_req            out  memory request (high only in WAIT)
//   dmem_we             out  1 = write
//   dmem_addr           out  word address, bits [1:0] always 0
//   dmem_wdata          out  store data
//   dmem_ack            in   transaction complete, rdata valid same cycle
//   dmem_rdata          in   load data
//   RegWrite_WB         out  registered MEM/WB write enable
//   Write_register_WB   out  registered MEM/WB destination register
//   Write_data_WB       out  registered MEM/WB write data
//   mem_error           out  registered one-cycle error pulse
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALU_result_MEM,
    input  logic [31:0] Read_Data_2_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic        MemToReg_MEM,
    input  logic        RegWrite_MEM,
    input  logic [4:0]  Write_register_MEM,
    output logic        stall_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        RegWrite_WB,
    output logic [4:0]  Write_register_WB,
    output logic [31:0] Write_data_WB,
    output logic        mem_error
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [29:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              regWrite_q, regWrite_d;
    logic [4:0]        writeReg_q, writeReg_d;
    logic [31:0]       writeData_q, writeData_d;
    logic              memError_q, memError_d;

    logic              acc;
    logic              mis;
    logic              timeoutHit;

    assign acc        = MemRead_MEM | MemWrite_MEM;
    assign mis        = acc & (ALU_result_MEM[1:0] != 2'b00);
    assign timeoutHit = (state_q == ST_WAIT) && !dmem_ack && (cnt_q == CNT_LAST);

    // Next-state and MEM/WB next-value logic. Any cycle that does not
    // retire an instruction loads a bubble, so RegWrite_WB stays 0 while a
    // memory access is outstanding.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        regWrite_d  = 1'b0;
        writeReg_d  = 5'd0;
        writeData_d = 32'd0;
        memError_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!acc) begin
                    regWrite_d  = RegWrite_MEM;
                    writeReg_d  = Write_register_MEM;
                    writeData_d = ALU_result_MEM;
                end else if (mis) begin
                    memError_d = 1'b1;
                end else begin
                    // The latched request is the only source of the memory
                    // interface outputs. They therefore stay stable for the
                    // whole WAIT period, whatever EX/MEM does.
                    addr_d  = ALU_result_MEM[31:2];
                    wdata_d = Read_Data_2_MEM;
                    we_d    = MemWrite_MEM;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // An ack takes priority over the timeout in the final cycle.
                if (dmem_ack) begin
                    regWrite_d  = RegWrite_MEM;
                    writeReg_d  = Write_register_MEM;
                    writeData_d = MemToReg_MEM ? dmem_rdata : ALU_result_MEM;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else if (timeoutHit) begin
                    memError_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The stall is released in the ack/abort cycle itself, so upstream
    // advances on the same edge that retires the access. It is forced low
    // while reset is held.
    always_comb begin
        stall_MEM = 1'b0;
        if (rst_n) begin
            if (state_q == ST_IDLE) begin
                stall_MEM = acc & !mis;
            end else begin
                stall_MEM = !dmem_ack & !timeoutHit;
            end
        end
    end

    assign dmem_req   = (state_q == ST_WAIT);
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q, 2'b00};
    assign dmem_wdata = wdata_q;

    assign RegWrite_WB       = regWrite_q;
    assign Write_register_WB = writeReg_q;
    assign Write_data_WB     = writeData_q;
    assign mem_error         = memError_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            regWrite_q  <= 1'b0;
            writeReg_q  <= 5'd0;
            writeData_q <= 32'd0;
            memError_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
            memError_q  <= memError_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl
// ----------------------------------------------------------------------------
// Directed bench for mem_access_ctrl with TIMEOUT = 4. Inputs change 1 ns
// after a rising edge, and outputs are sampled a further 1 ns later.
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALU_result_MEM;
    logic [31:0] Read_Data_2_MEM;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic        MemToReg_MEM;
    logic        RegWrite_MEM;
    logic [4:0]  Write_register_MEM;
    logic        stall_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        RegWrite_WB;
    logic [4:0]  Write_register_WB;
    logic [31:0] Write_data_WB;
    logic        mem_error;

    int assertCount = 0;
    int failCount   = 0;

    mem_access_ctrl #(
        .TIMEOUT(4),
        .CNT_W  (3)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ALU_result_MEM    (ALU_result_MEM),
        .Read_Data_2_MEM   (Read_Data_2_MEM),
        .MemRead_MEM       (MemRead_MEM),
        .MemWrite_MEM      (MemWrite_MEM),
        .MemToReg_MEM      (MemToReg_MEM),
        .RegWrite_MEM      (RegWrite_MEM),
        .Write_register_MEM(Write_register_MEM),
        .stall_MEM         (stall_MEM),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .RegWrite_WB       (RegWrite_WB),
        .Write_register_WB (Write_register_WB),
        .Write_data_WB     (Write_data_WB),
        .mem_error         (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the EX/MEM side of the DUT and let it settle.
    task automatic applyStimulus(input logic        rd,
                                 input logic        wr,
                                 input logic        m2r,
                                 input logic        rw,
                                 input logic [4:0]  dst,
                                 input logic [31:0] alu,
                                 input logic [31:0] rd2);
        MemRead_MEM        = rd;
        MemWrite_MEM       = wr;
        MemToReg_MEM       = m2r;
        RegWrite_MEM       = rw;
        Write_register_MEM = dst;
        ALU_result_MEM     = alu;
        Read_Data_2_MEM    = rd2;
        #1;
    endtask

    task automatic setMem(input logic ack, input logic [31:0] rdata);
        dmem_ack   = ack;
        dmem_rdata = rdata;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        setMem(1'b0, 32'd0);

        // Reset state
        checkOutput("rst_stall",   {31'd0, stall_MEM},        32'd0);
        checkOutput("rst_req",     {31'd0, dmem_req},         32'd0);
        checkOutput("rst_we",      {31'd0, dmem_we},          32'd0);
        checkOutput("rst_addr",    dmem_addr,                 32'd0);
        checkOutput("rst_wdata",   dmem_wdata,                32'd0);
        checkOutput("rst_regwr",   {31'd0, RegWrite_WB},      32'd0);
        checkOutput("rst_wreg",    {27'd0, Write_register_WB}, 32'd0);
        checkOutput("rst_wdat",    Write_data_WB,             32'd0);
        checkOutput("rst_err",     {31'd0, mem_error},        32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // ALU passthrough
        $display("[TB] ALU passthrough");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'd0);
        checkOutput("alu_stall",   {31'd0, stall_MEM},        32'd0);
        checkOutput("alu_req",     {31'd0, dmem_req},         32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        checkOutput("alu_regwr",   {31'd0, RegWrite_WB},      32'd1);
        checkOutput("alu_wreg",    {27'd0, Write_register_WB}, 32'd5);
        checkOutput("alu_wdat",    Write_data_WB,             32'h0000_1234);
        checkOutput("alu_err",     {31'd0, mem_error},        32'd0);

        // Load with ack on the third WAIT cycle
        $display("[TB] Load, 3-cycle memory");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h0000_0040, 32'd0);
        checkOutput("ld_idle_stall", {31'd0, stall_MEM},      32'd1);
        checkOutput("ld_idle_req",   {31'd0, dmem_req},       32'd0);
        tick();
        checkOutput("ld_w1_req",   {31'd0, dmem_req},         32'd1);
        checkOutput("ld_w1_stall", {31'd0, stall_MEM},        32'd1);
        checkOutput("ld_w1_addr",  dmem_addr,                 32'h0000_0040);
        checkOutput("ld_w1_we",    {31'd0, dmem_we},          32'd0);
        checkOutput("ld_w1_bubble", {31'd0, RegWrite_WB},     32'd0);
        tick();
        checkOutput("ld_w2_stall", {31'd0, stall_MEM},        32'd1);
        checkOutput("ld_w2_addr",  dmem_addr,                 32'h0000_0040);
        checkOutput("ld_w2_we",    {31'd0, dmem_we},          32'd0);
        tick();
        setMem(1'b1, 32'hDEAD_BEEF);
        checkOutput("ld_w3_req",   {31'd0, dmem_req},         32'd1);
        checkOutput("ld_w3_stall", {31'd0, stall_MEM},        32'd0);
        checkOutput("ld_w3_addr",  dmem_addr,                 32'h0000_0040);
        tick();
        setMem(1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        checkOutput("ld_regwr",    {31'd0, RegWrite_WB},      32'd1);
        checkOutput("ld_wreg",     {27'd0, Write_register_WB}, 32'd8);
        checkOutput("ld_wdat",     Write_data_WB,             32'hDEAD_BEEF);
        checkOutput("ld_done_req", {31'd0, dmem_req},         32'd0);

        // Zero-wait store
        $display("[TB] Zero-wait store");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0010, 32'hA5A5_A5A5);
        checkOutput("st_idle_stall", {31'd0, stall_MEM},      32'd1);
        tick();
        setMem(1'b1, 32'h1111_2222);
        checkOutput("st_req",      {31'd0, dmem_req},         32'd1);
        checkOutput("st_we",       {31'd0, dmem_we},          32'd1);
        checkOutput("st_addr",     dmem_addr,                 32'h0000_0010);
        checkOutput("st_wdata",    dmem_wdata,                32'hA5A5_A5A5);
        checkOutput("st_stall",    {31'd0, stall_MEM},        32'd0);
        tick();
        setMem(1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        checkOutput("st_regwr",    {31'd0, RegWrite_WB},      32'd0);
        checkOutput("st_done_req", {31'd0, dmem_req},         32'd0);
        checkOutput("st_err",      {31'd0, mem_error},        32'd0);

        // Misaligned load
        $display("[TB] Misaligned load");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0042, 32'd0);
        checkOutput("mis_stall",   {31'd0, stall_MEM},        32'd0);
        checkOutput("mis_req",     {31'd0, dmem_req},         32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        checkOutput("mis_err",     {31'd0, mem_error},        32'd1);
        checkOutput("mis_regwr",   {31'd0, RegWrite_WB},      32'd0);
        checkOutput("mis_req2",    {31'd0, dmem_req},         32'd0);
        tick();
        checkOutput("mis_err_end", {31'd0, mem_error},        32'd0);

        // Timeout after 4 WAIT cycles, then a late ack
        $display("[TB] Timeout");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0080, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("to_req_%0d", k),   {31'd0, dmem_req},  32'd1);
            checkOutput($sformatf("to_stall_%0d", k), {31'd0, stall_MEM}, (k == 3) ? 32'd0 : 32'd1);
            checkOutput($sformatf("to_err_%0d", k),   {31'd0, mem_error}, 32'd0);
            if (k == 3) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
            end
            tick();
        end
        checkOutput("to_err",      {31'd0, mem_error},        32'd1);
        checkOutput("to_regwr",    {31'd0, RegWrite_WB},      32'd0);
        checkOutput("to_req_end",  {31'd0, dmem_req},         32'd0);
        setMem(1'b1, 32'hCAFE_F00D);
        checkOutput("late_stall",  {31'd0, stall_MEM},        32'd0);
        checkOutput("late_req",    {31'd0, dmem_req},         32'd0);
        tick();
        setMem(1'b0, 32'd0);
        checkOutput("late_regwr",  {31'd0, RegWrite_WB},      32'd0);
        checkOutput("late_wdat",   Write_data_WB,             32'd0);
        checkOutput("late_err",    {31'd0, mem_error},        32'd0);

        // Asynchronous reset during WAIT
        $display("[TB] Reset mid-WAIT");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0020, 32'h5555_0000);
        tick();
        checkOutput("rw_req_pre",  {31'd0, dmem_req},         32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rw_req",      {31'd0, dmem_req},         32'd0);
        checkOutput("rw_stall",    {31'd0, stall_MEM},        32'd0);
        checkOutput("rw_addr",     dmem_addr,                 32'd0);
        checkOutput("rw_regwr",    {31'd0, RegWrite_WB},      32'd0);
        checkOutput("rw_err",      {31'd0, mem_error},        32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("rw_idle_req", {31'd0, dmem_req},         32'd0);
        checkOutput("rw_idle_err", {31'd0, mem_error},        32'd0);

        // A load straight after reset release proves the FSM restarted in IDLE
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h0000_0044, 32'd0);
        checkOutput("rw_ld_stall", {31'd0, stall_MEM},        32'd1);
        tick();
        setMem(1'b1, 32'h0BAD_F00D);
        checkOutput("rw_ld_addr",  dmem_addr,                 32'h0000_0044);
        tick();
        setMem(1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        checkOutput("rw_ld_wdat",  Write_data_WB,             32'h0BAD_F00D);
        checkOutput("rw_ld_wreg",  {27'd0, Write_register_WB}, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage controller sitting between the EX/MEM pipeline register outputs and the data memory. It consumes the `*_MEM` signals that register produces.
- Load/store: runs a req/ack transaction to data memory, stalls the upstream pipeline until the transaction completes, then loads the MEM/WB register.
- Non-memory instructions: pass through to MEM/WB in one cycle with no stall.
- Also flags misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT, 16: max cycles in WAIT without dmem_ack before abort; must be >= 2.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ALU_result_MEM  in  32  effective address for load/store; passthrough result otherwise.
- Read_Data_2_MEM  in  32  store data.
- MemRead_MEM  in  1  load.
- MemWrite_MEM  in  1  store.
- MemToReg_MEM  in  1  writeback selects memory data.
- RegWrite_MEM  in  1  instruction writes the register file.
- Write_register_MEM  in  5  destination register.
- stall_MEM  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM registers.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address, bits [1:0] always 0.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  transaction complete; rdata valid in the same cycle.
- dmem_rdata  in  32  load data.
- RegWrite_WB  out  1  registered.
- Write_register_WB  out  5  registered.
- Write_data_WB  out  32  registered; dmem_rdata if MemToReg_MEM, else ALU_result_MEM.
- mem_error  out  1  registered; 1-cycle pulse.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset:
  - state = IDLE, counter = 0.
  - All registered outputs 0 (RegWrite_WB, Write_register_WB, Write_data_WB, mem_error).
  - dmem_req = 0, stall_MEM = 0.
  - Latched addr/wdata/we cleared.
- Definitions:
  - acc = MemRead_MEM | MemWrite_MEM.
  - mis = acc & (ALU_result_MEM[1:0] != 0).
  - If MemRead_MEM and MemWrite_MEM are both 1, the access is treated as a store.
- IDLE:
  - !acc: stall_MEM = 0. At the clock edge, MEM/WB <= {RegWrite_MEM, Write_register_MEM, ALU_result_MEM}. Latency 1 cycle.
  - mis: stall_MEM = 0, no request issued. MEM/WB loads with RegWrite_WB = 0 and mem_error = 1 for one cycle. Stay IDLE.
  - acc & !mis: stall_MEM = 1. Latch addr = ALU_result_MEM, wdata = Read_Data_2_MEM, we = MemWrite_MEM. MEM/WB loads a bubble (RegWrite_WB = 0). Counter = 0. Go to WAIT.
- WAIT:
  - dmem_req = 1; dmem_addr, dmem_wdata and dmem_we are driven from the latches and stay stable until ack or abort.
  - No ack: stall_MEM = 1, counter += 1.
  - dmem_ack = 1: stall_MEM = 0 in that cycle, so upstream advances on the same edge. MEM/WB <= {RegWrite_MEM, Write_register_MEM, MemToReg_MEM ? dmem_rdata : ALU_result_MEM}. Go to IDLE.
  - Abort: counter == TIMEOUT-1 with no ack. stall_MEM = 0, RegWrite_WB = 0, mem_error = 1, go to IDLE. A late ack arriving in IDLE is ignored.
- Latency: a load/store occupies MEM for 2 + N cycles, where N is the number of WAIT cycles before ack.
- Outside WAIT: dmem_req = 0.
- mem_error:
  - Asserted only in the cycle after a misaligned access or an abort.
  - Misaligned and abort cannot occur on the same edge.
- rst_n asserted during WAIT:
  - Immediate return to IDLE, dmem_req drops asynchronously.
  - No MEM/WB update and no mem_error.
- Back-to-back memory ops: the next op enters IDLE detection on the cycle after ack, so there are no extra bubbles beyond the IDLE detect cycle.

Test Plan:
- Reset mid-WAIT: rst_n = 0 with dmem_req = 1 -> dmem_req = 0 and all outputs 0 within the same cycle (asynchronous); state IDLE after release.
- ALU op: RegWrite_MEM = 1, Write_register_MEM = 5, ALU_result_MEM = 0x1234 -> after the next edge RegWrite_WB = 1, Write_register_WB = 5, Write_data_WB = 0x1234; stall_MEM never 1.
- Load with 3-cycle memory:
  - Stimulus: MemRead = 1, MemToReg = 1, addr = 0x40, dst = 8; ack arrives on the 3rd WAIT cycle with rdata = 0xDEADBEEF.
  - Response: stall_MEM high for 3 cycles (IDLE detect plus 2 WAIT); dmem_addr = 0x40 and dmem_we = 0 throughout WAIT.
  - Response: Write_data_WB = 0xDEADBEEF with RegWrite_WB = 1.
- Zero-wait store: MemWrite = 1, addr = 0x10, data = 0xA5A5A5A5, ack in the first WAIT cycle -> dmem_we = 1, dmem_wdata = 0xA5A5A5A5; stall_MEM = 1 for exactly 1 cycle; RegWrite_WB = 0.
- Misaligned load: addr = 0x42 -> dmem_req never asserts; mem_error = 1 for 1 cycle; RegWrite_WB = 0; stall_MEM = 0.
- Timeout: TIMEOUT = 4, ack never arrives -> dmem_req high for 4 cycles, then mem_error = 1 and RegWrite_WB = 0; stall_MEM = 0 in the 4th WAIT cycle; a later ack has no effect.
